mii_rx_frame_writer: RTL and testbench

- MII receive front end for the slave ring port.
- Detects preamble and SFD on the 4-bit MII receive bus, assembles nibbles into bytes (low nibble first), and writes each byte into the rx dual-port RAM port A (data, address, write-enable).
- Reports frame completion, byte length, overflow and dribble status to the higher-level slave logic.
- Sits between the PHY RX pins (ENETx_RX_DATA/RX_DV on ENETx_RX_CLK) and rx_dual_port_ram_8bit.

---
 rtl/mii_rx_frame_writer.sv | 174 +++++++++++++++++
 tb/tb_mii_rx_frame_writer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mii_rx_frame_writer.sv
// MII receive front end: preamble/SFD detect, nibble-to-byte assembly, RAM port-A writes, frame status.
// Optional FCS check is built when MII_RX_CRC_CHECK_EN is defined; otherwise CrcError is tied low.
module mii_rx_frame_writer #(
  parameter int ADDR_W          = 8,
  parameter int MIN_PRE_NIBBLES = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              MRxDV,
  input  logic [3:0]        MRxD,
  output logic [7:0]        RxData,
  output logic              RxValid,
  output logic [ADDR_W-1:0] RxRamAddr,
  output logic              FrameDone,
  output logic [ADDR_W:0]   FrameLen,
  output logic              Overflow,
  output logic              Dribble,
  output logic              CrcError,
  output logic              Busy
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state;
  logic [3:0]        r_pre_cnt;
  logic              r_phase;
  logic [3:0]        r_low;
  logic [ADDR_W-1:0] r_addr;
  logic              r_full;
  logic              r_ovf;
  logic [ADDR_W:0]   r_cnt;
  logic [7:0]        r_rx_data;
  logic              r_rx_valid;
  logic [ADDR_W-1:0] r_rx_addr;
  logic              r_done;
  logic [ADDR_W:0]   r_frame_len;
  logic              r_overflow;
  logic              r_dribble;
  logic [7:0]        w_byte;

  assign w_byte = {MRxD, r_low};

`ifdef MII_RX_CRC_CHECK_EN
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  logic [31:0] r_crc;
  logic        r_crc_err;

  // Reflected CRC-32, one byte per call, data consumed LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_crc     <= 32'hFFFF_FFFF;
      r_crc_err <= 1'b0;
    end else begin
      case (r_state)
        PRE:  if (MRxDV && MRxD == 4'hD) r_crc <= 32'hFFFF_FFFF;
        DATA: begin
          if (MRxDV && r_phase)  r_crc     <= crc_byte(r_crc, w_byte);
          if (!MRxDV)            r_crc_err <= (r_crc != CRC_RESIDUE);
        end
        default: ;
      endcase
    end
  end

  assign CrcError = r_crc_err;
`else
  assign CrcError = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= DROP;
      r_pre_cnt   <= '0;
      r_phase     <= 1'b0;
      r_low       <= '0;
      r_addr      <= '0;
      r_full      <= 1'b0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_addr   <= '0;
      r_done      <= 1'b0;
      r_frame_len <= '0;
      r_overflow  <= 1'b0;
      r_dribble   <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (MRxDV) begin
            if (MRxD == 4'h5) begin
              r_state   <= PRE;
              r_pre_cnt <= 4'd1;
            end else begin
              r_state <= DROP;
            end
          end
        end
        PRE: begin
          if (!MRxDV) begin
            r_state <= IDLE;
          end else if (MRxD == 4'h5) begin
            if (r_pre_cnt != 4'hF) r_pre_cnt <= r_pre_cnt + 4'd1;
          end else if (MRxD == 4'hD && r_pre_cnt >= 4'(MIN_PRE_NIBBLES)) begin
            r_state   <= DATA;
            r_phase   <= 1'b0;
            r_addr    <= '0;
            r_rx_addr <= '0;
            r_full    <= 1'b0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
          end else begin
            r_state <= DROP;
          end
        end
        DATA: begin
          if (MRxDV) begin
            if (!r_phase) begin
              r_low   <= MRxD;
              r_phase <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              // Once the last RAM location is written, later bytes are counted but dropped.
              if (!r_full) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= w_byte;
                r_rx_addr  <= r_addr;
                if (r_addr == ADDR_MAX) r_full <= 1'b1;
                else                    r_addr <= r_addr + 1'b1;
              end else begin
                r_ovf <= 1'b1;
              end
              if (r_cnt != LEN_MAX) r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_state     <= IDLE;
            r_done      <= 1'b1;
            r_frame_len <= r_cnt;
            r_overflow  <= r_ovf;
            r_dribble   <= r_phase;
          end
        end
        DROP: begin
          if (!MRxDV) r_state <= IDLE;
        end
        default: r_state <= DROP;
      endcase
    end
  end

  assign RxData    = r_rx_data;
  assign RxValid   = r_rx_valid;
  assign RxRamAddr = r_rx_addr;
  assign FrameDone = r_done;
  assign FrameLen  = r_frame_len;
  assign Overflow  = r_overflow;
  assign Dribble   = r_dribble;
  assign Busy      = (r_state == PRE) || (r_state == DATA);

endmodule

// File: tb/tb_mii_rx_frame_writer.sv
// Self-checking bench for mii_rx_frame_writer: directed and random frames against a frame-level reference model.
// Define MII_RX_CRC_CHECK_EN for both files to exercise the FCS check.
module tb_mii_rx_frame_writer;

  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;
`ifdef MII_RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          MRxDV = 1'b0;
  logic [3:0]    MRxD = 4'h0;
  logic [7:0]    RxData;
  logic          RxValid;
  logic [AW-1:0] RxRamAddr;
  logic          FrameDone;
  logic [AW:0]   FrameLen;
  logic          Overflow;
  logic          Dribble;
  logic          CrcError;
  logic          Busy;

  mii_rx_frame_writer #(.ADDR_W(AW), .MIN_PRE_NIBBLES(7)) dut (
    .clk(clk), .reset_n(reset_n), .MRxDV(MRxDV), .MRxD(MRxD),
    .RxData(RxData), .RxValid(RxValid), .RxRamAddr(RxRamAddr),
    .FrameDone(FrameDone), .FrameLen(FrameLen), .Overflow(Overflow),
    .Dribble(Dribble), .CrcError(CrcError), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Entries: write = {cycle, addr, data}; done = {cycle, len, ovf, dribble, crcerr}
  logic [63:0] got_wr[$], exp_wr[$], got_done[$], exp_done[$];

  always @(negedge clk) begin
    if (RxValid)
      got_wr.push_back({32'(cyc), 16'(RxRamAddr), 8'h00, RxData});
    if (FrameDone)
      got_done.push_back({32'(cyc), 16'(FrameLen), 13'd0, Overflow, Dribble, CrcError});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Standard reflected CRC-32 of a byte stream, no final inversion.
  function automatic logic [31:0] crc_ref(input logic [7:0] b[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (b[i])
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return c;
  endfunction

  task automatic drive(input logic dv, input logic [3:0] d);
    @(negedge clk);
    MRxDV = dv;
    MRxD  = d;
  endtask

  // Sends one frame and records what the block should produce for it.
  task automatic run_frame(input int npre, input logic [3:0] sfd, input logic [7:0] b[$],
                           input bit drb, input int gap);
    bit acc;
    int n;
    acc = (npre >= 7) && (sfd == 4'hD);
    n   = b.size();
    for (int i = 0; i < npre; i++) drive(1'b1, 4'h5);
    drive(1'b1, sfd);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, b[i][3:0]);
      drive(1'b1, b[i][7:4]);
      if (acc && i < DEPTH) exp_wr.push_back({32'(cyc + 1), 16'(i), 8'h00, b[i]});
    end
    if (drb) drive(1'b1, 4'($urandom_range(0, 15)));
    drive(1'b0, 4'h0);
    if (acc)
      exp_done.push_back({32'(cyc + 1), 16'((n < DEPTH) ? n : DEPTH), 13'd0,
                          (n > DEPTH), drb, (CRC_EN && (crc_ref(b) != RESIDUE))});
    for (int i = 1; i < gap; i++) drive(1'b0, 4'h0);
  endtask

  task automatic check_all(input string tag);
    int m;
    repeat (4) @(negedge clk);
    chk({tag, "_nwr"}, 64'(got_wr.size()), 64'(exp_wr.size()));
    m = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
    for (int i = 0; i < m; i++) chk($sformatf("%s_wr%0d", tag, i), got_wr[i], exp_wr[i]);
    chk({tag, "_ndone"}, 64'(got_done.size()), 64'(exp_done.size()));
    m = (got_done.size() < exp_done.size()) ? got_done.size() : exp_done.size();
    for (int i = 0; i < m; i++) chk($sformatf("%s_done%0d", tag, i), got_done[i], exp_done[i]);
    got_wr.delete(); exp_wr.delete(); got_done.delete(); exp_done.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, 64'(RxData), 64'd0);
    chk({tag, "_valid"}, 64'(RxValid), 64'd0);
    chk({tag, "_addr"}, 64'(RxRamAddr), 64'd0);
    chk({tag, "_done"}, 64'(FrameDone), 64'd0);
    chk({tag, "_len"}, 64'(FrameLen), 64'd0);
    chk({tag, "_ovf"}, 64'(Overflow), 64'd0);
    chk({tag, "_drb"}, 64'(Dribble), 64'd0);
    chk({tag, "_crc"}, 64'(CrcError), 64'd0);
    chk({tag, "_busy"}, 64'(Busy), 64'd0);
  endtask

  initial begin
    logic [7:0]  pl[$];
    logic [31:0] fcs;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    pl = '{8'h12, 8'h34};
    run_frame(15, 4'hD, pl, 1'b0, 1);
    check_all("basic");

    pl = '{8'hAA, 8'hBB, 8'h55};
    run_frame(4, 4'hD, pl, 1'b0, 1);
    pl = '{8'h5A, 8'hC3};
    run_frame(7, 4'hD, pl, 1'b0, 1);
    check_all("shortpre");

    pl = '{8'h11, 8'h22};
    run_frame(8, 4'h7, pl, 1'b0, 2);
    run_frame(0, 4'hD, pl, 1'b0, 2);
    check_all("badsfd");

    drive(1'b1, 4'h5);
    drive(1'b1, 4'h5);
    chk("busy_pre", 64'(Busy), 64'd1);
    drive(1'b1, 4'h5);
    drive(1'b0, 4'h0);
    drive(1'b0, 4'h0);
    chk("busy_abort", 64'(Busy), 64'd0);
    check_all("preabort");

    pl.delete();
    for (int i = 0; i < 300; i++) pl.push_back(8'($urandom));
    run_frame(7, 4'hD, pl, 1'b0, 2);
    check_all("overflow");

    pl = '{8'h01, 8'hF0, 8'h7E};
    run_frame(9, 4'hD, pl, 1'b1, 2);
    check_all("dribble");

    pl.delete();
    run_frame(8, 4'hD, pl, 1'b0, 1);
    check_all("empty");

    for (int f = 0; f < 10; f++) begin
      pl.delete();
      for (int i = 0; i < int'($urandom_range(1, 30)); i++) pl.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        fcs = ~crc_ref(pl);
        pl.push_back(fcs[7:0]);  pl.push_back(fcs[15:8]);
        pl.push_back(fcs[23:16]); pl.push_back(fcs[31:24]);
      end
      run_frame(int'($urandom_range(4, 15)), 4'hD, pl, 1'($urandom_range(0, 1)),
                int'($urandom_range(1, 3)));
    end
    check_all("random");

    // Reset pulse mid-frame while the PHY keeps MRxDV high.
    for (int i = 0; i < 8; i++) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    drive(1'b1, 4'hC);
    drive(1'b1, 4'h3);
    exp_wr.push_back({32'(cyc + 1), 16'd0, 8'h00, 8'h3C});
    drive(1'b1, 4'h9);
    @(negedge clk);
    reset_n = 1'b0;
    MRxD    = 4'h7;
    @(negedge clk);
    chk_all_zero("midrst");
    reset_n = 1'b1;
    for (int i = 0; i < 9; i++) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    drive(1'b1, 4'h1);
    drive(1'b1, 4'h2);
    drive(1'b0, 4'h0);
    pl = '{8'hE1, 8'h2F};
    run_frame(7, 4'hD, pl, 1'b0, 1);
    check_all("rst");

    pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    run_frame(7, 4'hD, pl, 1'b0, 2);
    check_all("kat_good");
    chk("kat_good_len", 64'(FrameLen), 64'd13);
    chk("kat_good_crc", 64'(CrcError), 64'd0);
    pl[0] = pl[0] ^ 8'h01;
    run_frame(7, 4'hD, pl, 1'b0, 2);
    check_all("kat_bad");
    chk("kat_bad_len", 64'(FrameLen), 64'd13);
    chk("kat_bad_crc", 64'(CrcError), 64'(CRC_EN));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
